mod12_cmd_driver: RTL and testbench



---
 rtl/mod12_cmd_driver.sv | 159 +++++++++++++++
 tb/tb_mod12_cmd_driver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mod12_cmd_driver.sv
// Command-driven controller and self-checker for a mod-12 up/down counter.
// Accepts LOAD/UP/DOWN/RESET commands over valid/ready, drives the counter's
// control pins from registers, and runs a cycle-exact model of the counter
// so that any divergence on cnt_data_out is flagged and counted.
module mod12_cmd_driver #(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [3:0]        cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              cnt_reset,
  output logic              cnt_load,
  output logic              cnt_mode,
  output logic [3:0]        cnt_data_in,
  input  logic [3:0]        cnt_data_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [STEP_W-1:0] err_count,
  output logic [3:0]        exp_value,
  output logic              exp_known
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [1:0]        OP_LOAD  = 2'd0;
  localparam logic [1:0]        OP_UP    = 2'd1;
  localparam logic [1:0]        OP_DOWN  = 2'd2;
  localparam logic [1:0]        OP_RESET = 2'd3;
  localparam logic [STEP_W-1:0] ONE      = STEP_W'(1);
  localparam logic [STEP_W-1:0] EC_MAX   = '1;

  state_t            state, state_n;
  logic [STEP_W-1:0] rem, rem_n;           // EXEC cycles left, including current
  logic              cnt_reset_n, cnt_load_n, cnt_mode_n;
  logic [3:0]        cnt_data_in_n;
  logic              cmd_ready_n, busy_n, done_n;
  logic [3:0]        exp_next;
  logic              mism;

  // Next state and the register inputs for every control output; outputs are
  // computed one cycle ahead so that all of them come straight from flops.
  always_comb begin
    state_n       = state;
    rem_n         = rem;
    cnt_reset_n   = 1'b0;
    cnt_load_n    = 1'b0;
    cnt_mode_n    = cnt_mode;              // direction is sticky
    cnt_data_in_n = cnt_data_in;
    cmd_ready_n   = 1'b0;
    busy_n        = 1'b0;
    done_n        = 1'b0;
    unique case (state)
      S_INIT: begin
        state_n     = S_IDLE;
        cmd_ready_n = 1'b1;
      end
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_n = S_EXEC;
          busy_n  = 1'b1;
          rem_n   = ONE;
          unique case (cmd_op)
            OP_LOAD: begin
              cnt_load_n    = 1'b1;
              cnt_data_in_n = cmd_data;
            end
            OP_RESET: cnt_reset_n = 1'b1;
            OP_UP, OP_DOWN: begin
              cnt_mode_n = (cmd_op == OP_UP);
              rem_n      = (cmd_steps == '0) ? ONE : cmd_steps;
            end
            default: ;
          endcase
        end else begin
          cmd_ready_n = 1'b1;
        end
      end
      S_EXEC: begin
        // LOAD/RESET last one cycle, so only the stepping ops stay here;
        // their pins already hold the right values.
        busy_n = 1'b1;
        rem_n  = rem - ONE;
        if (rem_n == '0) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
      end
      S_DONE: begin
        state_n     = S_IDLE;
        cmd_ready_n = 1'b1;
      end
      default: state_n = S_INIT;
    endcase
  end

  // Control state and registered handshake/counter-pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_INIT;
      rem         <= '0;
      cnt_reset   <= 1'b1;
      cnt_load    <= 1'b0;
      cnt_mode    <= 1'b1;
      cnt_data_in <= 4'd0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      rem         <= rem_n;
      cnt_reset   <= cnt_reset_n;
      cnt_load    <= cnt_load_n;
      cnt_mode    <= cnt_mode_n;
      cnt_data_in <= cnt_data_in_n;
      cmd_ready   <= cmd_ready_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // Counter model: what the counter will show after this edge, given the pins
  // driven in this cycle, with the counter's own reset > load > count priority.
  always_comb begin
    exp_next = exp_value;
    if (cnt_reset)
      exp_next = 4'd0;
    else if (cnt_load)
      exp_next = cnt_data_in;
    else if (cnt_mode)
      exp_next = (exp_value == 4'd11) ? 4'd0 : exp_value + 4'd1;
    else
      exp_next = (exp_value == 4'd0) ? 4'd11 : exp_value - 4'd1;
  end

  assign mism = exp_known && (cnt_data_out != exp_value);

  // Model state plus mismatch reporting; err_count saturates rather than wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_value <= 4'd0;
      exp_known <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      exp_value <= exp_next;
      if (cnt_reset || cnt_load)
        exp_known <= 1'b1;
      err <= mism;
      if (mism && (err_count != EC_MAX))
        err_count <= err_count + ONE;
    end
  end

endmodule

// File: tb/tb_mod12_cmd_driver.sv
// Randomized self-checking bench for mod12_cmd_driver. A behavioural mod-12
// counter sits on the control pins (with an optional output corruption), and
// command sequencing expectations are derived from each issued command.
module tb_mod12_cmd_driver;
  localparam int STEP_W = 8;
  localparam int EC_MAX = (1 << STEP_W) - 1;
  localparam logic [1:0] OP_LOAD = 2'd0, OP_UP = 2'd1, OP_DOWN = 2'd2, OP_RESET = 2'd3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = '0;
  logic [3:0]        cmd_data = '0;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic              cmd_ready, cnt_reset, cnt_load, cnt_mode, busy, done, err, exp_known;
  logic [3:0]        cnt_data_in, cnt_data_out, exp_value;
  logic [STEP_W-1:0] err_count;

  // bench-side counter device and expectations
  logic [3:0] ctr_m = '0;
  logic       known_m = 1'b0, err_exp = 1'b0, mode_m = 1'b1, force_en = 1'b0, chk_en = 1'b0;
  int         errc_m = 0;
  logic       mism_w;
  int         n_chk = 0, n_err = 0;

  assign cnt_data_out = force_en ? (ctr_m ^ 4'h8) : ctr_m;
  assign mism_w       = known_m && (cnt_data_out != ctr_m);

  mod12_cmd_driver #(.STEP_W(STEP_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_steps(cmd_steps),
    .cnt_reset(cnt_reset), .cnt_load(cnt_load), .cnt_mode(cnt_mode),
    .cnt_data_in(cnt_data_in), .cnt_data_out(cnt_data_out),
    .busy(busy), .done(done), .err(err), .err_count(err_count),
    .exp_value(exp_value), .exp_known(exp_known)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ctr_next(logic [3:0] v, logic r, logic l, logic [3:0] d, logic up);
    if (r) return 4'd0;
    if (l) return d;
    if (up) return (v == 4'd11) ? 4'd0 : 4'((v + 1) % 16);
    return (v == 4'd0) ? 4'd11 : 4'(v - 1);
  endfunction

  // counter device and mismatch bookkeeping, advanced on each active edge
  always @(posedge clk) begin
    ctr_m <= ctr_next(ctr_m, cnt_reset, cnt_load, cnt_data_in, cnt_mode);
    if (reset) begin
      known_m <= 1'b0;
      err_exp <= 1'b0;
      errc_m  <= 0;
    end else begin
      err_exp <= mism_w;
      if (mism_w && errc_m < EC_MAX) errc_m <= errc_m + 1;
      if (cnt_reset || cnt_load) known_m <= 1'b1;
    end
  end

  // per-cycle model checks, sampled on the inactive edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("exp_known", exp_known, known_m);
      if (known_m) chk("exp_value", exp_value, ctr_m);
      chk("err", err, err_exp);
      chk("err_count", err_count, errc_m);
      chk("cnt_mode", cnt_mode, mode_m);
    end
  end

  // called at negedge+1; returns at negedge+1 in the first IDLE cycle
  task automatic do_reset(input int cyc);
    reset = 1'b1; cmd_valid = 1'b0; force_en = 1'b0; mode_m = 1'b1;
    repeat (cyc) @(negedge clk);
    chk("rst_cnt_reset", cnt_reset, 1);   chk("rst_cnt_load", cnt_load, 0);
    chk("rst_cnt_mode", cnt_mode, 1);     chk("rst_data_in", cnt_data_in, 0);
    chk("rst_cmd_ready", cmd_ready, 0);   chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);             chk("rst_err", err, 0);
    chk("rst_err_count", err_count, 0);   chk("rst_exp_value", exp_value, 0);
    chk("rst_exp_known", exp_known, 0);
    chk_en = 1'b1;
    #1 reset = 1'b0;                        // rest of this cycle is INIT
    @(negedge clk);
    chk("init_ready", cmd_ready, 1);     chk("init_cnt_reset", cnt_reset, 0);
    chk("init_known", exp_known, 1);     chk("init_exp_value", exp_value, 0);
    #1;
  endtask

  task automatic idle(input int g);
    repeat (g) begin
      @(negedge clk);
      chk("idle_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
      #1;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data,
                         input logic [STEP_W-1:0] steps, input bit junk);
    int n;
    n = (op == OP_UP || op == OP_DOWN) ? ((steps == 0) ? 1 : int'(steps)) : 1;
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_steps = steps;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = 4'($urandom); cmd_steps = STEP_W'($urandom);
    if (op == OP_UP) mode_m = 1'b1;
    else if (op == OP_DOWN) mode_m = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("exec_busy", busy, 1);   chk("exec_done", done, 0);
      chk("exec_ready", cmd_ready, 0);
      chk("exec_load", cnt_load, op == OP_LOAD);
      chk("exec_reset", cnt_reset, op == OP_RESET);
      if (op == OP_LOAD) chk("exec_data_in", cnt_data_in, data);
      #1 if (junk) cmd_valid = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk("done_pulse", done, 1);  chk("done_busy", busy, 1);
    chk("done_ready", cmd_ready, 0);
    chk("done_load", cnt_load, 0); chk("done_reset", cnt_reset, 0);
    if (op == OP_LOAD)  chk("load_value", exp_value, data);
    if (op == OP_RESET) chk("reset_value", exp_value, 0);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("post_done", done, 0); chk("post_busy", busy, 0);
    chk("post_ready", cmd_ready, 1);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk); #1;
    do_reset(3);
    // free-running up count after reset
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("free_up", exp_value, i % 12);
      #1;
    end

    // directed sequences
    run_cmd(OP_LOAD, 4'd10, 0, 0); run_cmd(OP_UP, 4'd0, 3, 0); idle(3);
    run_cmd(OP_LOAD, 4'd0, 0, 0);  run_cmd(OP_DOWN, 4'd0, 2, 0); idle(4);
    run_cmd(OP_LOAD, 4'd14, 0, 0); run_cmd(OP_UP, 4'd0, 2, 0);
    run_cmd(OP_LOAD, 4'd12, 0, 0); run_cmd(OP_DOWN, 4'd0, 1, 0);
    run_cmd(OP_RESET, 4'd0, 0, 0); run_cmd(OP_UP, 4'd0, 0, 0); idle(2);

    // injected mismatches: three cycles, then saturation
    do_reset(2);
    force_en = 1'b1;
    repeat (3) @(negedge clk);
    #1 force_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_count_3", err_count, 3);
    #1 force_en = 1'b1;
    repeat (300) @(negedge clk);
    chk("err_count_sat", err_count, EC_MAX);
    #1 force_en = 1'b0;
    idle(2);

    // reset in the middle of a long UP
    force_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 force_en = 1'b0;
    chk("ready_before_abort", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_UP; cmd_steps = 8'd8;
    @(posedge clk); #1 cmd_valid = 1'b0; mode_m = 1'b1;
    repeat (3) begin @(negedge clk); chk("abort_busy", busy, 1); end
    #1 reset = 1'b1; mode_m = 1'b1;
    repeat (2) begin @(negedge clk); chk("abort_no_done", done, 0); end
    chk("abort_known", exp_known, 0);
    chk("abort_err_count", err_count, 0);
    chk("abort_cnt_reset", cnt_reset, 1);
    chk("abort_ready", cmd_ready, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_back", cmd_ready, 1); chk("abort_exp0", exp_value, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    chk("abort_exp1", exp_value, 1);
    #1;

    // randomized command stream with occasional output corruption
    for (int k = 0; k < 40; k++) begin
      run_cmd(2'($urandom), 4'($urandom), STEP_W'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        force_en = 1'b1;
        @(negedge clk); #1 force_en = 1'b0;
        chk("rand_ready", cmd_ready, 1);
      end
      idle($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
